// File: rtl/tag_alloc_pkg.sv
// Shared types and sizing helpers for the tag allocation arbiter.
// The typedefs match the default configuration; parameterised modules derive their own widths.
package tag_alloc_pkg;

  localparam int unsigned NumReqDef      = 4;
  localparam int unsigned NumTagsDef     = 16;
  localparam int unsigned NumTagOutDef   = 2;
  localparam int unsigned NumTagInDef    = 2;
  localparam int unsigned MaxInflightDef = 8;

  // Index width that stays at least one bit wide for single-entry arrays.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned TagWidthDef    = idx_width(NumTagsDef);
  localparam int unsigned ReqIdxWidthDef = idx_width(NumReqDef);
  localparam int unsigned CntWidthDef    = $clog2(MaxInflightDef + 1);

  typedef logic [TagWidthDef-1:0]    tag_t;
  typedef logic [ReqIdxWidthDef-1:0] req_idx_t;
  typedef logic [CntWidthDef-1:0]    cnt_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/tag_rr_matcher.sv
// Round-robin matcher: pairs the n-th eligible requester (walking up from rr_ptr)
// with the n-th valid get port, and reports the pointer to use after this cycle.
module tag_rr_matcher
  import tag_alloc_pkg::*;
#(
  parameter int unsigned NumReq       = 4,
  parameter int unsigned NumPort      = 2,
  localparam int unsigned ReqIdxWidth  = idx_width(NumReq),
  localparam int unsigned PortIdxWidth = idx_width(NumPort)
) (
  input  logic [NumReq-1:0]                    eligible_i,
  input  logic [ReqIdxWidth-1:0]               rr_ptr_i,
  input  logic [NumPort-1:0]                   port_valid_i,
  output logic [NumReq-1:0]                    grant_o,
  output logic [NumReq-1:0][PortIdxWidth-1:0]  grant_port_o,
  output logic [NumPort-1:0]                   port_get_o,
  output logic                                 any_grant_o,
  output logic [ReqIdxWidth-1:0]               rr_ptr_next_o
);

  localparam int unsigned SumWidth = ReqIdxWidth + 1;

  always_comb begin
    logic [SumWidth-1:0]    idx;
    logic [ReqIdxWidth-1:0] r;
    logic [ReqIdxWidth-1:0] last;
    logic [NumPort-1:0]     used;
    logic                   got;
    logic                   any;
    // NOTE: every variable is given a value before any branch, so no latch is inferred.
    grant_o       = '0;
    grant_port_o  = '0;
    used          = '0;
    last          = '0;
    any           = 1'b0;
    got           = 1'b0;
    r             = '0;
    idx           = '0;
    for (int i = 0; i < NumReq; i++) begin
      idx = SumWidth'(rr_ptr_i) + SumWidth'(i);
      if (idx >= SumWidth'(NumReq)) idx = idx - SumWidth'(NumReq);
      r   = idx[ReqIdxWidth-1:0];
      got = 1'b0;
      if (eligible_i[r]) begin
        for (int k = 0; k < NumPort; k++) begin
          if (!got && port_valid_i[k] && !used[k]) begin
            got             = 1'b1;
            used[k]         = 1'b1;
            grant_o[r]      = 1'b1;
            grant_port_o[r] = PortIdxWidth'(k);
            last            = r;
            any             = 1'b1;
          end
        end
      end
    end
    port_get_o    = used;
    any_grant_o   = any;
    rr_ptr_next_o = rr_ptr_i;
    idx           = SumWidth'(last) + SumWidth'(1);
    if (any) rr_ptr_next_o = (idx >= SumWidth'(NumReq)) ? '0 : idx[ReqIdxWidth-1:0];
  end

endmodule

// File: rtl/tag_alloc_arbiter.sv
// Shares tag_queue get ports among requesters with round-robin fairness, tracks
// tag ownership and per-requester in-flight limits, validates frees and drains on flush.
module tag_alloc_arbiter
  import tag_alloc_pkg::*;
#(
  parameter int unsigned NumReq      = NumReqDef,
  parameter int unsigned NumTags     = NumTagsDef,
  parameter int unsigned NumTagOut   = NumTagOutDef,
  parameter int unsigned NumTagIn    = NumTagInDef,
  parameter int unsigned MaxInflight = MaxInflightDef,
  localparam int unsigned TagWidth     = idx_width(NumTags),
  localparam int unsigned CntWidth     = $clog2(MaxInflight + 1),
  localparam int unsigned ReqIdxWidth  = idx_width(NumReq),
  localparam int unsigned PortIdxWidth = idx_width(NumTagOut)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  output logic [NumReq*TagWidth-1:0]    req_tag_o,
  input  logic [NumTagIn-1:0]           free_i,
  input  logic [NumTagIn*TagWidth-1:0]  free_tag_i,
  output logic [NumTagOut-1:0]          tq_get_o,
  input  logic [NumTagOut-1:0]          tq_valid_i,
  input  logic [NumTagOut*TagWidth-1:0] tq_tag_i,
  output logic [NumTagIn-1:0]           tq_free_o,
  output logic [NumTagIn*TagWidth-1:0]  tq_tag_o,
  input  logic                          flush_i,
  output logic                          flush_done_o,
  output logic [NumReq*CntWidth-1:0]    inflight_o,
  output logic                          err_o
);

  state_e                                  state_q, state_d;
  logic [ReqIdxWidth-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [NumReq-1:0][CntWidth-1:0]         inflight_q, inflight_d;
  logic [NumTags-1:0]                      owner_valid_q, owner_valid_d;
  logic [NumTags-1:0][ReqIdxWidth-1:0]     owner_q, owner_d;
  logic                                    err_q, err_d;

  logic [NumTagOut-1:0][TagWidth-1:0]      tq_tags;
  logic [NumTagIn-1:0][TagWidth-1:0]       free_tags;
  logic [NumReq-1:0][TagWidth-1:0]         req_tags;
  logic [NumTagIn-1:0][TagWidth-1:0]       fwd_tags;

  logic [NumReq-1:0]                       eligible;
  logic [NumReq-1:0]                       grant;
  logic [NumReq-1:0][PortIdxWidth-1:0]     grant_port;
  logic                                    any_grant;
  logic [ReqIdxWidth-1:0]                  rr_ptr_next;
  logic [NumTagIn-1:0]                     free_legal;
  logic [NumTagIn-1:0]                     free_bad;
  logic                                    inflight_any;

  assign tq_tags   = tq_tag_i;
  assign free_tags = free_tag_i;

  always_comb begin
    eligible = '0;
    for (int r = 0; r < NumReq; r++) begin
      eligible[r] = req_valid_i[r] && (inflight_q[r] < CntWidth'(MaxInflight)) &&
                    (state_q == RUN);
    end
  end

  tag_rr_matcher #(
    .NumReq  (NumReq),
    .NumPort (NumTagOut)
  ) u_matcher (
    .eligible_i    (eligible),
    .rr_ptr_i      (rr_ptr_q),
    .port_valid_i  (tq_valid_i),
    .grant_o       (grant),
    .grant_port_o  (grant_port),
    .port_get_o    (tq_get_o),
    .any_grant_o   (any_grant),
    .rr_ptr_next_o (rr_ptr_next)
  );

  always_comb begin
    req_tags = '0;
    for (int r = 0; r < NumReq; r++) begin
      if (grant[r]) req_tags[r] = tq_tags[grant_port[r]];
    end
  end

  assign req_ready_o = grant;
  assign req_tag_o   = req_tags;

  // A repeated tag within one cycle is honoured only on its lowest free port.
  always_comb begin
    logic dup;
    free_legal = '0;
    free_bad   = '0;
    fwd_tags   = '0;
    dup        = 1'b0;
    for (int j = 0; j < NumTagIn; j++) begin
      dup = 1'b0;
      for (int jj = 0; jj < j; jj++) begin
        if (free_i[jj] && (free_tags[jj] == free_tags[j])) dup = 1'b1;
      end
      free_legal[j] = free_i[j] && owner_valid_q[free_tags[j]] && !dup;
      free_bad[j]   = free_i[j] && !free_legal[j];
      if (free_legal[j]) fwd_tags[j] = free_tags[j];
    end
  end

  assign tq_free_o = free_legal;
  assign tq_tag_o  = fwd_tags;

  // Frees are applied before grants; a granted tag is never currently owned, so the two never collide.
  always_comb begin
    owner_valid_d = owner_valid_q;
    owner_d       = owner_q;
    inflight_d    = inflight_q;
    for (int j = 0; j < NumTagIn; j++) begin
      if (free_legal[j]) begin
        owner_valid_d[free_tags[j]] = 1'b0;
        inflight_d[owner_q[free_tags[j]]] = inflight_d[owner_q[free_tags[j]]] - CntWidth'(1);
      end
    end
    for (int r = 0; r < NumReq; r++) begin
      if (grant[r]) begin
        owner_valid_d[tq_tags[grant_port[r]]] = 1'b1;
        owner_d[tq_tags[grant_port[r]]]       = ReqIdxWidth'(r);
        inflight_d[r]                         = inflight_d[r] + CntWidth'(1);
      end
    end
  end

  assign err_d        = err_q | (|free_bad);
  assign rr_ptr_d     = any_grant ? rr_ptr_next : rr_ptr_q;
  assign inflight_any = |inflight_q;

  always_comb begin
    state_d      = state_q;
    flush_done_o = 1'b0;
    unique case (state_q)
      RUN: begin
        if (flush_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!inflight_any) begin
          flush_done_o = 1'b1;
          state_d      = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RUN;
      rr_ptr_q      <= '0;
      inflight_q    <= '0;
      owner_valid_q <= '0;
      err_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      inflight_q    <= inflight_d;
      owner_valid_q <= owner_valid_d;
      err_q         <= err_d;
    end
  end

  // NOTE: owner indices are only read when owner_valid_q is set, so this array needs no reset.
  always_ff @(posedge clk_i) begin
    owner_q <= owner_d;
  end

  assign inflight_o = inflight_q;
  assign err_o      = err_q;

  for (genvar k = 0; k < NumTagOut; k++) begin : g_tq_chk
    a_no_owned_tag : assert property (@(posedge clk_i) disable iff (!rst_ni)
      tq_get_o[k] |-> !owner_valid_q[tq_tags[k]]);
  end

endmodule

// File: tb/tb_tag_alloc_arbiter.sv
// Self-checking bench for tag_alloc_arbiter: directed scenarios plus a random soak
// against a small tag_queue model, all compared through a scoreboard queue.
`timescale 1ns/1ps
module tb_tag_alloc_arbiter;
  import tag_alloc_pkg::*;

  localparam int NR = 4;
  localparam int NT = 16;
  localparam int TW = 4;
  localparam int NO = 2;
  localparam int NI = 2;
  localparam int MI = 8;
  localparam int CW = 4;

  logic              clk_i;
  logic              rst_ni;
  logic [NR-1:0]     req_valid_i;
  logic [NR-1:0]     req_ready_o;
  logic [NR*TW-1:0]  req_tag_o;
  logic [NI-1:0]     free_i;
  logic [NI*TW-1:0]  free_tag_i;
  logic [NO-1:0]     tq_get_o;
  logic [NO-1:0]     tq_valid_i;
  logic [NO*TW-1:0]  tq_tag_i;
  logic [NI-1:0]     tq_free_o;
  logic [NI*TW-1:0]  tq_tag_o;
  logic              flush_i;
  logic              flush_done_o;
  logic [NR*CW-1:0]  inflight_o;
  logic              err_o;

  tag_alloc_arbiter #(
    .NumReq(NR), .NumTags(NT), .NumTagOut(NO), .NumTagIn(NI), .MaxInflight(MI)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_tag_o    (req_tag_o),
    .free_i       (free_i),
    .free_tag_i   (free_tag_i),
    .tq_get_o     (tq_get_o),
    .tq_valid_i   (tq_valid_i),
    .tq_tag_i     (tq_tag_i),
    .tq_free_o    (tq_free_o),
    .tq_tag_o     (tq_tag_o),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .inflight_o   (inflight_o),
    .err_o        (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef enum int {S_READY, S_TAG, S_GET, S_FREE, S_FTAG, S_ERR, S_DONE, S_INFL,
                    S_NREADY, S_NGET} sig_e;
  typedef struct {
    sig_e        sig;
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  task automatic expect_sig(input string name, input sig_e sig, input int idx,
                            input logic [31:0] val);
    exp_t e;
    e.sig = sig; e.idx = idx; e.val = val; e.name = name;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] observe(input sig_e sig, input int idx);
    case (sig)
      S_READY:  return 32'(req_ready_o);
      S_TAG:    return 32'(req_tag_o[idx*TW +: TW]);
      S_GET:    return 32'(tq_get_o);
      S_FREE:   return 32'(tq_free_o);
      S_FTAG:   return 32'(tq_tag_o[idx*TW +: TW]);
      S_ERR:    return 32'(err_o);
      S_DONE:   return 32'(flush_done_o);
      S_INFL:   return 32'(inflight_o[idx*CW +: CW]);
      S_NREADY: return 32'($countones(req_ready_o));
      S_NGET:   return 32'($countones(tq_get_o));
      default:  return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic settle_and_check();
    exp_t e;
    #4;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, observe(e.sig, e.idx), e.val);
    end
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic tick();
    settle_and_check();
    advance();
  endtask

  task automatic drive(input logic [NR-1:0] rv, input logic [NO-1:0] tv, input int t0,
                       input int t1, input logic [NI-1:0] fv, input int f0, input int f1,
                       input logic fl);
    req_valid_i = rv;
    tq_valid_i  = tv;
    tq_tag_i    = {tag_t'(t1), tag_t'(t0)};
    free_i      = fv;
    free_tag_i  = {tag_t'(f1), tag_t'(f0)};
    flush_i     = fl;
  endtask

  task automatic idle();
    drive('0, '0, 0, 0, '0, 0, 0, 1'b0);
  endtask

  task automatic exp_comb(input string n, input logic [NR-1:0] rdy, input logic [NO-1:0] get,
                          input logic [NI-1:0] fr);
    expect_sig({n, "_ready"}, S_READY, 0, 32'(rdy));
    expect_sig({n, "_get"},   S_GET,   0, 32'(get));
    expect_sig({n, "_free"},  S_FREE,  0, 32'(fr));
  endtask

  task automatic apply_reset();
    idle();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // Soak state: tag_queue free list, ownership and per-requester counts.
  int fl_q[$];
  bit own_v[NT];
  int own_r[NT];
  int cnt[NR];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b1;
    idle();

    // Reset state
    apply_reset();
    exp_comb("rst", '0, '0, '0);
    expect_sig("rst_err", S_ERR, 0, 0);
    expect_sig("rst_done", S_DONE, 0, 0);
    for (int r = 0; r < NR; r++) expect_sig($sformatf("rst_infl%0d", r), S_INFL, r, 0);
    tick();

    // Single requester, both ports valid: lowest port wins
    apply_reset();
    drive(4'b0001, 2'b11, 3, 5, '0, 0, 0, 1'b0);
    exp_comb("single", 4'b0001, 2'b01, '0);
    expect_sig("single_tag0", S_TAG, 0, 3);
    tick();
    idle();
    expect_sig("single_infl0", S_INFL, 0, 1);
    expect_sig("single_idle_ready", S_READY, 0, 0);
    tick();

    // All requesters for four cycles: pairs rotate {0,1},{2,3},...
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      drive(4'b1111, 2'b11, 2*c, 2*c+1, '0, 0, 0, 1'b0);
      exp_comb($sformatf("rr%0d", c), (c % 2 == 0) ? 4'b0011 : 4'b1100, 2'b11, '0);
      expect_sig($sformatf("rr%0d_tagA", c), S_TAG, (c % 2 == 0) ? 0 : 2, 32'(2*c));
      expect_sig($sformatf("rr%0d_tagB", c), S_TAG, (c % 2 == 0) ? 1 : 3, 32'(2*c+1));
      tick();
    end
    idle();
    for (int r = 0; r < NR; r++) expect_sig($sformatf("rr_infl%0d", r), S_INFL, r, 2);
    tick();

    // In-flight limit on requester 1
    apply_reset();
    for (int c = 0; c < MI; c++) begin
      drive(4'b0010, 2'b01, c, 0, '0, 0, 0, 1'b0);
      exp_comb($sformatf("lim_fill%0d", c), 4'b0010, 2'b01, '0);
      expect_sig($sformatf("lim_fill%0d_tag", c), S_TAG, 1, 32'(c));
      tick();
    end
    drive(4'b0010, 2'b01, 8, 0, '0, 0, 0, 1'b0);
    exp_comb("lim_full", '0, '0, '0);
    expect_sig("lim_full_infl", S_INFL, 1, 8);
    tick();
    drive(4'b0010, 2'b01, 8, 0, 2'b01, 7, 0, 1'b0);
    exp_comb("lim_free7", '0, '0, 2'b01);
    expect_sig("lim_free7_ftag", S_FTAG, 0, 7);
    tick();
    drive(4'b0010, 2'b01, 8, 0, 2'b01, 6, 0, 1'b0);
    exp_comb("lim_net0", 4'b0010, 2'b01, 2'b01);
    expect_sig("lim_net0_tag", S_TAG, 1, 8);
    expect_sig("lim_net0_ftag", S_FTAG, 0, 6);
    expect_sig("lim_net0_infl", S_INFL, 1, 7);
    tick();
    drive(4'b0010, 2'b01, 9, 0, '0, 0, 0, 1'b0);
    exp_comb("lim_refill", 4'b0010, 2'b01, '0);
    expect_sig("lim_refill_infl", S_INFL, 1, 7);
    tick();
    drive(4'b0010, 2'b01, 10, 0, '0, 0, 0, 1'b0);
    exp_comb("lim_again", '0, '0, '0);
    expect_sig("lim_again_infl", S_INFL, 1, 8);
    tick();

    // Illegal frees: unowned tag, then the same tag twice in one cycle
    apply_reset();
    drive(4'b0001, 2'b01, 4, 0, '0, 0, 0, 1'b0);
    exp_comb("err_grant", 4'b0001, 2'b01, '0);
    expect_sig("err_grant_tag", S_TAG, 0, 4);
    tick();
    drive('0, '0, 0, 0, 2'b01, 9, 0, 1'b0);
    exp_comb("err_unowned", '0, '0, 2'b00);
    expect_sig("err_unowned_err", S_ERR, 0, 0);
    expect_sig("err_unowned_infl", S_INFL, 0, 1);
    tick();
    drive('0, '0, 0, 0, 2'b11, 4, 4, 1'b0);
    exp_comb("err_dup", '0, '0, 2'b01);
    expect_sig("err_dup_ftag0", S_FTAG, 0, 4);
    expect_sig("err_dup_err", S_ERR, 0, 1);
    tick();
    idle();
    expect_sig("err_sticky1", S_ERR, 0, 1);
    expect_sig("err_infl0", S_INFL, 0, 0);
    tick();
    idle();
    expect_sig("err_sticky2", S_ERR, 0, 1);
    tick();

    // Flush with outstanding tags; a grant is still allowed in the flush cycle
    apply_reset();
    drive(4'b0011, 2'b11, 1, 2, '0, 0, 0, 1'b0);
    exp_comb("fl_g0", 4'b0011, 2'b11, '0);
    tick();
    drive(4'b0100, 2'b01, 3, 0, '0, 0, 0, 1'b1);
    exp_comb("fl_g1", 4'b0100, 2'b01, '0);
    expect_sig("fl_g1_tag", S_TAG, 2, 3);
    expect_sig("fl_g1_done", S_DONE, 0, 0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      drive(4'b1111, 2'b11, 6, 7, 2'b01, c, 0, c == 1);
      exp_comb($sformatf("fl_drain%0d", c), '0, '0, 2'b01);
      expect_sig($sformatf("fl_drain%0d_done", c), S_DONE, 0, 0);
      tick();
    end
    drive(4'b1111, 2'b11, 6, 7, '0, 0, 0, 1'b0);
    exp_comb("fl_done", '0, '0, '0);
    expect_sig("fl_done_pulse", S_DONE, 0, 1);
    for (int r = 0; r < NR; r++) expect_sig($sformatf("fl_infl%0d", r), S_INFL, r, 0);
    tick();
    drive(4'b1111, 2'b11, 6, 7, '0, 0, 0, 1'b0);
    exp_comb("fl_resume", 4'b1001, 2'b11, '0);
    expect_sig("fl_resume_tag3", S_TAG, 3, 6);
    expect_sig("fl_resume_tag0", S_TAG, 0, 7);
    expect_sig("fl_resume_done", S_DONE, 0, 0);
    tick();

    // Flush with nothing outstanding completes one cycle later
    apply_reset();
    drive('0, '0, 0, 0, '0, 0, 0, 1'b1);
    expect_sig("fl0_req_done", S_DONE, 0, 0);
    tick();
    idle();
    expect_sig("fl0_done", S_DONE, 0, 1);
    tick();
    drive(4'b0001, 2'b01, 0, 0, '0, 0, 0, 1'b0);
    expect_sig("fl0_after_done", S_DONE, 0, 0);
    expect_sig("fl0_after_ready", S_READY, 0, 1);
    tick();

    // Random soak against a tag_queue model
    apply_reset();
    fl_q.delete();
    for (int t = 0; t < NT; t++) begin
      fl_q.push_back(t);
      own_v[t] = 1'b0;
      own_r[t] = 0;
    end
    for (int r = 0; r < NR; r++) cnt[r] = 0;
    begin
      int frees_done = 0;
      int cyc = 0;
      while (frees_done < 1000 && cyc < 20000) begin
        logic [NR-1:0] rv, elig;
        logic [NO-1:0] tv, got_ports;
        logic [NI-1:0] fv;
        int nv, nf, n_el, t0, t1;
        int owned[$];
        int ftag[NI];
        int gtag[NR];
        logic [NR-1:0] gv;
        cyc++;
        rv = NR'($urandom_range(0, (1 << NR) - 1));
        nv = (fl_q.size() < NO) ? fl_q.size() : NO;
        tv = '0;
        for (int k = 0; k < nv; k++) tv[k] = 1'b1;
        t0 = (nv > 0) ? fl_q[0] : 0;
        t1 = (nv > 1) ? fl_q[1] : 0;
        owned.delete();
        for (int t = 0; t < NT; t++) if (own_v[t]) owned.push_back(t);
        owned.shuffle();
        nf = $urandom_range(0, NI);
        if (nf > owned.size()) nf = owned.size();
        fv = '0;
        for (int j = 0; j < NI; j++) begin
          ftag[j] = (j < nf) ? owned[j] : 0;
          if (j < nf) fv[j] = 1'b1;
        end
        drive(rv, tv, t0, t1, fv, ftag[0], ftag[1], 1'b0);
        elig = '0;
        for (int r = 0; r < NR; r++) elig[r] = rv[r] && (cnt[r] < MI);
        n_el = $countones(elig);
        expect_sig("soak_ngrant", S_NREADY, 0, 32'((n_el < nv) ? n_el : nv));
        expect_sig("soak_nget", S_NGET, 0, 32'((n_el < nv) ? n_el : nv));
        expect_sig("soak_free", S_FREE, 0, 32'(fv));
        expect_sig("soak_err", S_ERR, 0, 0);
        for (int r = 0; r < NR; r++) expect_sig("soak_infl", S_INFL, r, 32'(cnt[r]));
        settle_and_check();
        gv = req_ready_o;
        got_ports = tq_get_o;
        for (int r = 0; r < NR; r++) begin
          gtag[r] = int'(req_tag_o[r*TW +: TW]);
          if (gv[r]) begin
            check("soak_dup", 32'(own_v[gtag[r]]), 0);
            check("soak_offered", 32'((gtag[r] == t0 && got_ports[0]) ||
                                      (nv > 1 && gtag[r] == t1 && got_ports[1])), 1);
          end
        end
        advance();
        for (int j = 0; j < nf; j++) begin
          own_v[ftag[j]] = 1'b0;
          cnt[own_r[ftag[j]]]--;
          frees_done++;
        end
        for (int k = NO - 1; k >= 0; k--) begin
          if (got_ports[k] && k < fl_q.size()) fl_q.delete(k);
        end
        for (int j = 0; j < nf; j++) fl_q.push_back(ftag[j]);
        for (int r = 0; r < NR; r++) begin
          if (gv[r]) begin
            own_v[gtag[r]] = 1'b1;
            own_r[gtag[r]] = r;
            cnt[r]++;
          end
        end
      end
      check("soak_frees_reached", 32'(frees_done >= 1000), 1);
    end
    idle();
    expect_sig("soak_final_err", S_ERR, 0, 0);
    for (int r = 0; r < NR; r++) expect_sig("soak_final_infl", S_INFL, r, 32'(cnt[r]));
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
